// File: rtl/sound_pkg.sv
// sound_pkg: shared event codes, FSM encoding and default tone constants
package sound_pkg;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned DEF_PADDLE_HALF = 56818;
  localparam int unsigned DEF_WALL_HALF = 75757;
  localparam int unsigned DEF_SCORE_HALF = 28409;
  localparam int unsigned DEF_SCORE2_HALF = 18939;
  localparam int unsigned DEF_DUR_CYCLES = 250000;
  localparam int unsigned DEF_GAP_CYCLES = 25000;
  typedef enum logic [1:0] {EVT_NONE = 2'd0, EVT_PADDLE = 2'd1, EVT_WALL = 2'd2, EVT_SCORE = 2'd3} evt_t;
  typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, GAP = 2'd2} state_t;
endpackage

// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: game-event inputs and audio/status outputs of the sequencer
interface sound_sequencer_if;
  logic enable;
  logic paddle_hit;
  logic wall_hit;
  logic score1;
  logic score2;
  logic audio_out;
  logic busy;
  logic [1:0] cur_evt;
  modport master (output enable, paddle_hit, wall_hit, score1, score2, input audio_out, busy, cur_evt);
  modport slave (input enable, paddle_hit, wall_hit, score1, score2, output audio_out, busy, cur_evt);
endinterface

// File: rtl/tone_gen.sv
// tone_gen: square wave with period 2*half, counter and phase held at 0 while not running
module tone_gen #(
  parameter int unsigned HW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [HW-1:0] half,
  output logic          wave
);
  logic [HW-1:0] cnt;
  // count 0..half-1, toggling the phase on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      wave <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      wave <= 1'b0;
    end else if (cnt == half - HW'(1)) begin
      cnt <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + HW'(1);
    end
  end
endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: latches Pong sound events and plays them one at a time on a shared tone generator
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned PADDLE_HALF = DEF_PADDLE_HALF,
  parameter int unsigned WALL_HALF = DEF_WALL_HALF,
  parameter int unsigned SCORE_HALF = DEF_SCORE_HALF,
  parameter int unsigned SCORE2_HALF = DEF_SCORE2_HALF,
  parameter int unsigned DUR_CYCLES = DEF_DUR_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned HW = 17,
  parameter int unsigned DW = 20
) (
  input logic clk,
  input logic rst_n,
  sound_sequencer_if.slave bus
);
  localparam logic [DW-1:0] DUR_L = DW'(DUR_CYCLES - 1);
  localparam logic [DW-1:0] GAP_L = DW'(GAP_CYCLES - 1);
  state_t state, state_nx;
  evt_t cur_evt, winner;
  logic pend_score, pend_paddle, pend_wall, any, grant, last, note, run, wave;
  logic [DW-1:0] cnt;
  logic [HW-1:0] half;
  assign any = pend_score || pend_paddle || pend_wall;
  assign winner = pend_score ? EVT_SCORE : pend_paddle ? EVT_PADDLE : EVT_WALL;
  assign grant = bus.enable && state == IDLE && any;
  assign last = cnt == '0;
  assign run = bus.enable && state == TONE;
  assign half = cur_evt == EVT_PADDLE ? HW'(PADDLE_HALF) :
                cur_evt == EVT_WALL ? HW'(WALL_HALF) :
                note ? HW'(SCORE2_HALF) : HW'(SCORE_HALF);
  // one-deep pending flags; a new pulse wins over the grant clear, mute empties them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_score <= 1'b0;
      pend_paddle <= 1'b0;
      pend_wall <= 1'b0;
    end else begin
      pend_score <= bus.enable && (bus.score1 || bus.score2 || (pend_score && !(grant && winner == EVT_SCORE)));
      pend_paddle <= bus.enable && (bus.paddle_hit || (pend_paddle && !(grant && winner == EVT_PADDLE)));
      pend_wall <= bus.enable && (bus.wall_hit || (pend_wall && !(grant && winner == EVT_WALL)));
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: tone runs for its duration, then a gap; score gap loops back once for note 1
  always_comb begin
    state_nx = state;
    if (!bus.enable) state_nx = IDLE;
    else if (state == IDLE && any) state_nx = TONE;
    else if (state == TONE && last) state_nx = GAP;
    else if (state == GAP && last) state_nx = (cur_evt == EVT_SCORE && !note) ? TONE : IDLE;
  end
  // duration/gap counter, note index and the event currently playing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_evt <= EVT_NONE;
      note <= 1'b0;
      cnt <= '0;
    end else if (!bus.enable) begin
      cur_evt <= EVT_NONE;
      note <= 1'b0;
      cnt <= '0;
    end else if (grant) begin
      cur_evt <= winner;
      note <= 1'b0;
      cnt <= DUR_L;
    end else if (state == TONE) begin
      cnt <= last ? GAP_L : cnt - DW'(1);
    end else if (state == GAP && !last) begin
      cnt <= cnt - DW'(1);
    end else if (state == GAP && state_nx == TONE) begin
      note <= 1'b1;
      cnt <= DUR_L;
    end else if (state == GAP) begin
      cur_evt <= EVT_NONE;
    end
  end
  tone_gen #(.HW(HW)) u_tone (.clk(clk), .rst_n(rst_n), .run(run), .half(half), .wave(wave));
  // outputs: audio is gated combinationally so mute silences within the same cycle
  always_comb begin
    bus.busy = state != IDLE;
    bus.audio_out = wave && run;
    bus.cur_evt = cur_evt;
  end
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed vectors and multi-cycle sequences for sound_sequencer
module tb_sound_sequencer;
  localparam int DUR = 20;
  localparam int GAPN = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  sound_sequencer_if bus ();
  sound_sequencer #(
    .PADDLE_HALF(4), .WALL_HALF(6), .SCORE_HALF(2), .SCORE2_HALF(3),
    .DUR_CYCLES(DUR), .GAP_CYCLES(GAPN), .HW(17), .DW(20)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] mask;
    int evt;
    int h0;
    int h1;
  } vec_t;
  vec_t vecs [4];
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input logic [3:0] m);
    {bus.score2, bus.score1, bus.wall_hit, bus.paddle_hit} = m;
  endtask
  task automatic pulse(input logic [3:0] m);
    drive(m);
    @(negedge clk);
    drive(4'b0);
    chk("latency_busy", int'(bus.busy), 0);
    @(negedge clk);
  endtask
  task automatic check_note(input int evt, input int half, input int n, input bit inj);
    for (int k = 0; k < n; k++) begin
      chk("tone_busy", int'(bus.busy), 1);
      chk("tone_evt", int'(bus.cur_evt), evt);
      chk("tone_audio", int'(bus.audio_out), (k / half) % 2);
      bus.paddle_hit = inj && (k == 3 || k == 7 || k == 11);
      @(negedge clk);
    end
    bus.paddle_hit = 1'b0;
  endtask
  task automatic check_gap(input int evt);
    for (int g = 0; g < GAPN; g++) begin
      chk("gap_busy", int'(bus.busy), 1);
      chk("gap_evt", int'(bus.cur_evt), evt);
      chk("gap_audio", int'(bus.audio_out), 0);
      @(negedge clk);
    end
  endtask
  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_evt", int'(bus.cur_evt), 0);
      chk("idle_audio", int'(bus.audio_out), 0);
      @(negedge clk);
    end
  endtask
  initial begin
    vecs[0] = '{4'b0001, 1, 4, 0};
    vecs[1] = '{4'b0010, 2, 6, 0};
    vecs[2] = '{4'b0100, 3, 2, 3};
    vecs[3] = '{4'b1000, 3, 2, 3};
    bus.enable = 1'b1;
    drive(4'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_evt", int'(bus.cur_evt), 0);
    chk("rst_audio", int'(bus.audio_out), 0);
    rst_n = 1'b1;
    check_idle(5);
    for (int v = 0; v < 4; v++) begin
      pulse(vecs[v].mask);
      check_note(vecs[v].evt, vecs[v].h0, DUR, 1'b0);
      check_gap(vecs[v].evt);
      if (vecs[v].h1 != 0) begin
        check_note(vecs[v].evt, vecs[v].h1, DUR, 1'b0);
        check_gap(vecs[v].evt);
      end
      check_idle(3);
    end
    pulse(4'b0011);
    check_note(1, 4, DUR, 1'b0);
    check_gap(1);
    check_idle(1);
    check_note(2, 6, DUR, 1'b0);
    check_gap(2);
    check_idle(10);
    pulse(4'b0010);
    check_note(2, 6, DUR, 1'b1);
    check_gap(2);
    check_idle(1);
    check_note(1, 4, DUR, 1'b0);
    check_gap(1);
    check_idle(10);
    pulse(4'b1100);
    check_note(3, 2, DUR, 1'b0);
    check_gap(3);
    check_note(3, 3, DUR, 1'b0);
    check_gap(3);
    check_idle(5);
    pulse(4'b0001);
    check_note(1, 4, 6, 1'b0);
    chk("pre_mute_audio", int'(bus.audio_out), 1);
    bus.enable = 1'b0;
    bus.paddle_hit = 1'b1;
    #1;
    chk("mute_audio_comb", int'(bus.audio_out), 0);
    chk("mute_busy_same_cycle", int'(bus.busy), 1);
    @(negedge clk);
    bus.paddle_hit = 1'b0;
    chk("mute_busy", int'(bus.busy), 0);
    chk("mute_evt", int'(bus.cur_evt), 0);
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    check_idle(15);
    pulse(4'b0001);
    bus.wall_hit = 1'b1;
    @(negedge clk);
    bus.wall_hit = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_audio", int'(bus.audio_out), 1);
    chk("pre_reset_evt", int'(bus.cur_evt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_audio", int'(bus.audio_out), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_evt", int'(bus.cur_evt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Arbitrates and schedules the Pong sound events (paddle hit, wall hit, score) onto one shared square-wave tone generator.
- Latches single-cycle event pulses from the game logic.
- Grants them one at a time by fixed priority and sequences each tone's period, duration and inter-tone gap.
- A score plays a two-note jingle. The block drives the audio pin directly.

Parameters:
- PADDLE_HALF, 56818, half-period in clk cycles for the paddle tone (440 Hz at 50 MHz)
- WALL_HALF, 75757, half-period for the wall tone (330 Hz)
- SCORE_HALF, 28409, half-period for score note 1 (880 Hz)
- SCORE2_HALF, 18939, half-period for score note 2 (1320 Hz)
- DUR_CYCLES, 250000, length of each note in clk cycles (5 ms)
- GAP_CYCLES, 25000, silence between consecutive notes or events (0.5 ms)
- HW, 17, width of half-period values; must hold the largest half-period
- DW, 20, width of the duration/gap counter

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  sound enable; 0 = mute
- paddle_hit  input  1  one-cycle event pulse
- wall_hit  input  1  one-cycle event pulse
- score1  input  1  one-cycle pulse, player 1 scored
- score2  input  1  one-cycle pulse, player 2 scored
- audio_out  output  1  square-wave audio, 0 when silent
- busy  output  1  1 in TONE or GAP state
- cur_evt  output  2  event being played: 0 none, 1 paddle, 2 wall, 3 score

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all pending flags = 0; counters = 0.
  - audio_out = 0, busy = 0, cur_evt = 0.
- Pending flags:
  - pend_score, pend_paddle, pend_wall are one deep each; repeats coalesce.
  - A flag sets on the edge after its pulse; score1 and score2 share pend_score.
  - Set and clear in the same cycle: set wins (the flag stays 1).
- Arbitration: fixed priority score > paddle > wall, evaluated only in IDLE.
- IDLE:
  - If any flag is set, next edge: state = TONE, cur_evt = winner, winner's flag cleared, note = 0, dur_cnt = DUR_CYCLES-1, tone counter = 0, audio phase = 0.
  - Latency: pulse at cycle N gives busy = 1 at cycle N+2.
- TONE:
  - Tone counter counts 0..half-1. At half-1 it wraps to 0 and audio_out toggles, so the period is exactly 2*half cycles.
  - The first rising edge of audio_out comes half cycles after TONE entry.
  - half is selected from cur_evt and note: score note 0 uses SCORE_HALF, note 1 uses SCORE2_HALF.
  - dur_cnt decrements each cycle. At 0, next edge: state = GAP, gap_cnt = GAP_CYCLES-1, audio_out = 0.
- GAP:
  - audio_out = 0; gap_cnt decrements each cycle.
  - At 0, if cur_evt = score and note = 0: note = 1, return to TONE with counters reloaded.
  - Otherwise go to IDLE with cur_evt = 0. busy stays 1 throughout GAP.
- An event arriving during TONE/GAP (same or different type) is not a retrigger. It queues and plays after the current sequence completes.
- No preemption; a score arriving mid paddle-tone waits.
- Mute:
  - When enable = 0: pulses are ignored and all flags cleared every cycle.
  - State goes to IDLE on the next edge, audio_out = 0 combinationally, busy = 0, cur_evt = 0 on that edge.
  - Re-enable starts from IDLE with empty flags.
- Reset mid-tone: audio_out drops to 0 immediately (async); nothing resumes.
- GAP_CYCLES = 0 is illegal; minimum is 1. DUR_CYCLES must be ≥ 1.

Decomposition:
- Shared package sound_pkg:
  - event code constants EVT_NONE/PADDLE/WALL/SCORE;
  - state encoding IDLE/TONE/GAP;
  - default frequency constants and the CLK_HZ = 50_000_000 constant.
- Sub-module tone_gen: square-wave generator.
  - Inputs: clk, rst_n, run, half[HW-1:0]. Output: wave.
  - Counter and phase clear to 0 whenever run = 0.
- sound_sequencer holds the flags, arbiter, FSM, duration/gap counter and note index.

Test Plan (bench overrides PADDLE_HALF=4, WALL_HALF=6, SCORE_HALF=2, SCORE2_HALF=3, DUR_CYCLES=20, GAP_CYCLES=5):
- Paddle pulse at cycle 10 -> busy rises at cycle 12, cur_evt = 1, audio_out toggles every 4 cycles for 20 cycles, then 5 silent cycles, then busy = 0 and cur_evt = 0.
- score2 pulse -> note 0 toggles every 2 cycles for 20 cycles, gap of 5, note 1 toggles every 3 cycles for 20 cycles, gap of 5, then IDLE; cur_evt = 3 throughout.
- paddle_hit and wall_hit in the same cycle -> paddle plays first, wall (toggle every 6) starts right after paddle's gap; no third sequence.
- Three paddle pulses during a wall tone -> after the wall, exactly one paddle sequence plays (coalesced).
- enable dropped mid-tone -> audio_out = 0 the same cycle, IDLE and busy = 0 next edge; a pulse while muted produces no sound after re-enable.
- rst_n asserted mid-tone, asynchronously between edges -> audio_out, busy, cur_evt = 0 immediately; a pending wall flag set before reset does not play after release.
